// File: rtl/tc_alu_bist_ctrl.sv
// BIST sequencer: seeds the ALU BIST datapath, runs NUM_PATTERNS compaction cycles and checks MISR vs golden_sig.
// Latency: start edge to done=1 is NUM_PATTERNS+2 edges (+33 with TC_BIST_SCAN_CHECK_EN for the scan-chain check).
// Backpressure: none; start is ignored while busy, abort (or rst) cancels a session at any time.
module tc_alu_bist_ctrl #(
    parameter int          NUM_PATTERNS = 32,
    parameter logic [7:0]  SEED_A_INIT  = 8'hB3,
    parameter logic [7:0]  SEED_B_INIT  = 8'h3B,
    parameter logic [31:0] SCAN_PATTERN = 32'hA5C3_0F96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] misr_out,
    input  logic [15:0] golden_sig,
    output logic [7:0]  seed_a,
    output logic [7:0]  seed_b,
    output logic        set_en,
    output logic        si,
    output logic        si_en,
    output logic        test_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig_capture
);

`ifdef TC_BIST_SCAN_CHECK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_RUN, S_COMPARE, S_DONE, S_SCAN, S_SCAN_CHK
    } state_t;
    localparam state_t FIRST_STATE = S_SCAN;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_RUN, S_COMPARE, S_DONE
    } state_t;
    localparam state_t FIRST_STATE = S_SEED;
`endif

    localparam logic [7:0] LAST_CNT = 8'(NUM_PATTERNS - 1);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       scan_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = FIRST_STATE;
                        cnt_d   = 8'd0;
                    end
                end
                S_SEED: begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                end
                S_RUN: begin
                    if (cnt == LAST_CNT) begin
                        state_d = S_COMPARE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                S_COMPARE: state_d = S_DONE;
`ifdef TC_BIST_SCAN_CHECK_EN
                S_SCAN: begin
                    if (cnt == 8'd31) begin
                        state_d = S_SCAN_CHK;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                S_SCAN_CHK: state_d = S_SEED;
`endif
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_a      <= 8'd0;
            seed_b      <= 8'd0;
            set_en      <= 1'b0;
            test_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            sig_capture <= 16'd0;
        end else begin
            set_en  <= (state_d == S_SEED);
            test_en <= (state_d == S_SEED) || (state_d == S_RUN) || (state_d == S_COMPARE)
`ifdef TC_BIST_SCAN_CHECK_EN
                       || (state_d == S_SCAN)
`endif
                       ;
            busy    <= (state_d != S_IDLE) && (state_d != S_DONE);
            done    <= (state_d == S_DONE);
            if ((state_d == S_SEED) || (state_d == S_RUN) || (state_d == S_COMPARE)) begin
                seed_a <= SEED_A_INIT;
                seed_b <= SEED_B_INIT;
            end else begin
                seed_a <= 8'd0;
                seed_b <= 8'd0;
            end
            // An abort out of COMPARE leaves the previous capture untouched.
            if ((state == S_COMPARE) && (state_d == S_DONE)) begin
                sig_capture <= misr_out;
                pass        <= (misr_out == golden_sig) && scan_ok;
            end else if (state_d != S_DONE) begin
                pass <= 1'b0;
            end
        end
    end

`ifdef TC_BIST_SCAN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            si      <= 1'b0;
            si_en   <= 1'b0;
            scan_ok <= 1'b0;
        end else begin
            si_en <= (state_d == S_SCAN);
            si    <= (state_d == S_SCAN) ? SCAN_PATTERN[5'd31 - cnt_d[4:0]] : 1'b0;
            if (state == S_SCAN_CHK)
                scan_ok <= (misr_out == SCAN_PATTERN[31:16]);
        end
    end
`else
    assign si      = 1'b0;
    assign si_en   = 1'b0;
    assign scan_ok = 1'b1;
`endif

endmodule

// File: tb/tb_tc_alu_bist_ctrl.sv
// Directed bench for tc_alu_bist_ctrl: stimulus pushes expected results, a monitor pops them on each done rise.
// Also checks reset, seed/test_en timing, latency, abort, restart and optional scan-check behaviour.
module tb_tc_alu_bist_ctrl;
    localparam int NP = 32;
    localparam logic [31:0] SCAN_PAT = 32'hA5C3_0F96;
`ifdef TC_BIST_SCAN_CHECK_EN
    localparam int OFF = 33;
    localparam int SCAN_TE = 32;
`else
    localparam int OFF = 0;
    localparam int SCAN_TE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [15:0] misr_out, golden_sig;
    logic [7:0]  seed_a, seed_b;
    logic        set_en, si, si_en, test_en, busy, done, pass;
    logic [15:0] sig_capture;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        p;
        logic [15:0] sig;
    } exp_t;
    exp_t sb_q[$];

    tc_alu_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .misr_out(misr_out), .golden_sig(golden_sig),
        .seed_a(seed_a), .seed_b(seed_b), .set_en(set_en), .si(si), .si_en(si_en),
        .test_en(test_en), .busy(busy), .done(done), .pass(pass), .sig_capture(sig_capture)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected result per completed session.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_q !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pass", {31'd0, pass}, {31'd0, e.p});
                    chk("sb_sig_capture", {16'd0, sig_capture}, {16'd0, e.sig});
                end
            end
            done_q = done;
        end
    end

    // One full session; cycle i is observed on the negedge after start edge e0 + i.
    task automatic run_session(input logic [15:0] gold, input logic [15:0] cmp_val,
                               input logic [15:0] scan_val, input bit hold_start);
        exp_t  e;
        bit    got;
        int    set_cnt, te_cnt, i;
        logic [31:0] si_seq;
        @(negedge clk);
        golden_sig = gold;
        misr_out   = ~cmp_val;
        start      = 1'b1;
        e.p = (gold == cmp_val);
`ifdef TC_BIST_SCAN_CHECK_EN
        e.p = e.p && (scan_val == SCAN_PAT[31:16]);
`endif
        e.sig = cmp_val;
        sb_q.push_back(e);
        got = 1'b0; set_cnt = 0; te_cnt = 0; si_seq = 32'd0; i = 0;
        while (i < 200 && !got) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (i == 0) begin
                chk("busy_after_start", {31'd0, busy}, 32'd1);
                chk("done_cleared", {31'd0, done}, 32'd0);
            end
            if (i == OFF) begin
                chk("seed_set_en", {31'd0, set_en}, 32'd1);
                chk("seed_a", {24'd0, seed_a}, 32'h0000_00B3);
                chk("seed_b", {24'd0, seed_b}, 32'h0000_003B);
            end
            if (i < 32) si_seq = {si_seq[30:0], si};
            set_cnt += int'(set_en);
            te_cnt  += int'(test_en);
            if (done) begin
                got = 1'b1;
                chk("latency", i, OFF + NP + 2);
            end
            if (i == OFF + NP + 1) misr_out = cmp_val;
            else if (OFF != 0 && i == 32) misr_out = scan_val;
            else misr_out = ~cmp_val;
            i++;
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("set_en_cycles", set_cnt, 1);
        chk("test_en_cycles", te_cnt, NP + 2 + SCAN_TE);
`ifdef TC_BIST_SCAN_CHECK_EN
        chk("si_sequence", si_seq, SCAN_PAT);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        misr_out = 16'h0; golden_sig = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_pass", {30'd0, done, pass}, 32'd0);
        chk("rst_ctrl", {28'd0, set_en, test_en, si, si_en}, 32'd0);
        chk("rst_seeds_sig", {seed_a, seed_b, sig_capture}, 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        run_session(16'h5A3C, 16'h5A3C, 16'hA5C3, 1'b0);   // golden match
        @(negedge clk);
        chk("done_held", {30'd0, done, pass}, 32'd3);
        abort = 1'b1;                                        // abort in DONE
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_clears", {30'd0, done, pass}, 32'd0);
        chk("abort_done_keeps_sig", {16'd0, sig_capture}, 32'h5A3C);

        run_session(16'h5A3C, 16'h5A3D, 16'hA5C3, 1'b0);   // mismatch

        // Abort at RUN cycle 10 (cnt==10)
        @(negedge clk);
        golden_sig = 16'h1234; misr_out = 16'h1234; start = 1'b1;
        for (int i = 0; i <= OFF + 11; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {29'd0, busy, test_en, set_en}, 32'd0);
        chk("abort_done_pass", {30'd0, done, pass}, 32'd0);
        chk("abort_keeps_sig", {16'd0, sig_capture}, 32'h5A3D);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        run_session(16'hBEEF, 16'hBEEF, 16'hA5C3, 1'b0);   // normal after abort
        run_session(16'h0F0F, 16'h0F0F, 16'hA5C3, 1'b1);   // start held high
        run_session(16'h8001, 16'h8001, 16'hA5C3, 1'b0);   // restart from DONE
`ifdef TC_BIST_SCAN_CHECK_EN
        run_session(16'h8001, 16'h8001, 16'hA5C2, 1'b0);   // scan check fails
`endif

        // Mid-session synchronous reset
        @(negedge clk);
        start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ctrl", {27'd0, busy, test_en, set_en, si_en, done}, 32'd0);
        chk("rst_mid_seed_sig", {seed_a, seed_b, sig_capture}, 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
